weight_buffer_ctrl: RTL and testbench
=====================================

Name: weight_buffer_ctrl

Overview:
- Sequencer for the 64 x 512-bit weight buffer SRAM; it is the only block that drives the buffer's CEN/WEN/A/D/RETN pins.
- LOAD: streams weight words from the DMA/loader into a contiguous address window.
- READ: replays a window to the PE array a programmable number of times, supporting weight reuse across tiles.
- LOAD and READ are mutually exclusive phases.

Parameters:
DW, 512, buffer word width
AW, 6, buffer address width (DEPTH = 2^AW = 64)
REPW, 8, repeat-count width

Ports:
CLK  in  1  clock, all logic on posedge
RSTN  in  1  asynchronous active-low reset
ld_start  in  1  start-load pulse, sampled in IDLE only
ld_base  in  AW  first load address
ld_len  in  AW+1  words to load, 0..64
ld_valid  in  1  loader word valid
ld_data  in  DW  loader word
ld_ready  out  1  controller accepts ld_data this cycle
rd_start  in  1  start-read pulse, sampled in IDLE only
rd_base  in  AW  first read address
rd_len  in  AW+1  words per pass, 0..64
rd_rep  in  REPW  number of passes, 0 treated as 1
rd_stall  in  1  consumer stall, no read issued this cycle
rd_data  out  DW  weight word, pass-through of buf_Q
rd_valid  out  1  rd_data valid
rd_last  out  1  marks the final word of the final pass
busy  out  1  state != IDLE
done  out  1  one-cycle completion pulse
buf_CEN  out  1  buffer chip enable, active low
buf_WEN  out  1  buffer write enable, active low
buf_A  out  AW  buffer address
buf_D  out  DW  buffer write data
buf_RETN  out  1  buffer enable, low during reset
buf_Q  in  DW  buffer read data

Behaviour:
- Reset (async, RSTN=0):
  - state=IDLE; counters=0.
  - buf_CEN=1, buf_WEN=1, buf_A=0, buf_RETN=0.
  - ld_ready=0, rd_valid=0, rd_last=0, busy=0, done=0.
  - buf_RETN is a flop asynchronously cleared by RSTN and set to 1 on the first CLK edge after release.
  - Reset mid-LOAD or mid-READ aborts immediately; no done pulse; buffer contents are undefined.
- States: IDLE, LOAD, READ, DONE.
- IDLE:
  - ld_start=1 -> LOAD, latching ld_base/ld_len.
  - Otherwise rd_start=1 -> READ, latching rd_base/rd_len/rd_rep.
  - Simultaneous ld_start and rd_start: load wins; rd_start is dropped, not queued.
  - Starts seen outside IDLE are ignored.
  - A latched len of 0 goes directly to DONE with no buffer access.
- LOAD:
  - ld_ready=1.
  - buf_WEN = ~ld_valid (combinational); buf_D=ld_data; buf_A = (base + wcnt) mod 64.
  - Each ld_valid&ld_ready edge increments wcnt.
  - When wcnt reaches len-1 on a handshake edge -> DONE.
  - Addresses wrap modulo 64 (base=62, len=4 writes 62, 63, 0, 1).
- READ:
  - buf_CEN = rd_stall (combinational); buf_WEN=1; buf_A = (base + rcnt) mod 64.
  - Each unstalled cycle issues one read and advances rcnt. At len-1, rcnt resets to 0 and pcnt increments.
  - The read issued with pcnt=rep-1 and rcnt=len-1 is the last issue. The state goes to DONE on that edge.
  - Wrap-around follows the same modulo-64 rule as LOAD.
- Read latency is 1 cycle:
  - rd_valid is a flop that equals "read issued" from the previous cycle, aligned with buf_Q.
  - rd_last is a flop that equals "last read issued".
  - rd_data=buf_Q always. The buffer returns 0 on non-read cycles; consumers must qualify with rd_valid.
  - A stall inserts a rd_valid=0 bubble one cycle later; issued reads are never cancelled.
- DONE: done=1 for one cycle, then IDLE. A start arriving during DONE is ignored. The final rd_valid/rd_last beat coincides with done.
- busy=1 in LOAD, READ and DONE.
- Outside LOAD/READ: buf_CEN=1, buf_WEN=1, buf_A holds its last value, buf_D=0.

Test Plan:
- Reset then load: ld_base=0, ld_len=4, four consecutive beats D=1,2,3,4.
  - Required: buf_WEN=0 on 4 cycles at A=0..3; done pulses the cycle after the 4th beat; busy drops the following cycle.
- Load with gaps: ld_valid toggling 1,0,1,0.
  - Required: buf_WEN only on valid cycles; wcnt advances only on handshakes; 2 writes after 4 cycles.
- Read with repeat: rd_base=62, rd_len=3, rd_rep=2.
  - Required: A sequence 62, 63, 0, 62, 63, 0; rd_valid for 6 cycles lagging one cycle; rd_data matches loaded words; rd_last and done on the 6th beat only.
- Read with stall: rd_stall high for 2 cycles mid-pass.
  - Required: buf_CEN=1 on those cycles; two rd_valid=0 bubbles one cycle later; total valid beats unchanged.
- Edge cases:
  - rd_rep=0 behaves as 1.
  - rd_len=0 gives done one cycle after start with buf_CEN never 0.
  - Simultaneous ld_start/rd_start performs the load only.
  - ld_start during READ is ignored.
- Async reset mid-READ: RSTN low between edges.
  - Required: outputs return immediately to reset values, buf_RETN=0, no done pulse.
  - After release: a new load completes normally and buf_RETN=1 after the first edge.

Source files
------------

// File: rtl/weight_buffer_ctrl.sv
// Weight buffer sequencer: owns the 64 x DW single-port SRAM pins.
// LOAD streams loader words into a wrapping address window; READ replays a
// window rep times to the PE array with one cycle of read latency.
module weight_buffer_ctrl #(
    parameter int DW   = 512,
    parameter int AW   = 6,
    parameter int REPW = 8
) (
    input  logic            CLK,
    input  logic            RSTN,
    input  logic            ld_start,
    input  logic [AW-1:0]   ld_base,
    input  logic [AW:0]     ld_len,
    input  logic            ld_valid,
    input  logic [DW-1:0]   ld_data,
    output logic            ld_ready,
    input  logic            rd_start,
    input  logic [AW-1:0]   rd_base,
    input  logic [AW:0]     rd_len,
    input  logic [REPW-1:0] rd_rep,
    input  logic            rd_stall,
    output logic [DW-1:0]   rd_data,
    output logic            rd_valid,
    output logic            rd_last,
    output logic            busy,
    output logic            done,
    output logic            buf_CEN,
    output logic            buf_WEN,
    output logic [AW-1:0]   buf_A,
    output logic [DW-1:0]   buf_D,
    output logic            buf_RETN,
    input  logic [DW-1:0]   buf_Q
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_READ,
        S_DONE
    } state_t;

    state_t          state_reg;
    state_t          state_next;

    logic [AW-1:0]   base_reg;
    logic [AW:0]     len_reg;
    logic [REPW-1:0] rep_reg;
    logic [AW-1:0]   idx_reg;      // word index within the window (shared by LOAD and READ)
    logic [REPW-1:0] pass_reg;     // completed READ passes
    logic [AW-1:0]   a_hold_reg;   // last driven address, held while idle

    logic [AW-1:0]   addr;
    logic [AW:0]     len_m1;
    logic            idx_at_end;
    logic            pass_at_end;
    logic            wr_fire;
    logic            issue;
    logic            last_issue;

    // Address arithmetic truncates to AW bits, giving the modulo-DEPTH wrap.
    assign addr        = base_reg + idx_reg;
    assign len_m1      = len_reg - (AW+1)'(1);
    assign idx_at_end  = ({1'b0, idx_reg} == len_m1);
    assign pass_at_end = (pass_reg == rep_reg - REPW'(1));

    assign rd_data = buf_Q;
    assign busy    = (state_reg != S_IDLE);
    assign done    = (state_reg == S_DONE);

    // State register.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) state_reg <= S_IDLE;
        else       state_reg <= state_next;
    end

    // Next-state logic and SRAM pin drive.
    always_comb begin
        state_next = state_reg;
        ld_ready   = 1'b0;
        buf_CEN    = 1'b1;
        buf_WEN    = 1'b1;
        buf_A      = a_hold_reg;
        buf_D      = '0;
        wr_fire    = 1'b0;
        issue      = 1'b0;
        last_issue = 1'b0;
        case (state_reg)
            S_IDLE: begin
                // Load has priority; a coincident read start is simply dropped.
                if (ld_start)
                    state_next = (ld_len == '0) ? S_DONE : S_LOAD;
                else if (rd_start)
                    state_next = (rd_len == '0) ? S_DONE : S_READ;
            end
            S_LOAD: begin
                ld_ready = 1'b1;
                buf_CEN  = ~ld_valid;
                buf_WEN  = ~ld_valid;
                buf_D    = ld_data;
                buf_A    = addr;
                wr_fire  = ld_valid;
                if (ld_valid && idx_at_end)
                    state_next = S_DONE;
            end
            S_READ: begin
                buf_CEN    = rd_stall;
                buf_A      = addr;
                issue      = ~rd_stall;
                last_issue = ~rd_stall & idx_at_end & pass_at_end;
                if (last_issue)
                    state_next = S_DONE;
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Window registers, counters and the one-cycle-late read strobes.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            base_reg   <= '0;
            len_reg    <= '0;
            rep_reg    <= '0;
            idx_reg    <= '0;
            pass_reg   <= '0;
            a_hold_reg <= '0;
            rd_valid   <= 1'b0;
            rd_last    <= 1'b0;
        end else begin
            a_hold_reg <= buf_A;
            rd_valid   <= issue;
            rd_last    <= last_issue;
            case (state_reg)
                S_IDLE: begin
                    idx_reg  <= '0;
                    pass_reg <= '0;
                    if (ld_start) begin
                        base_reg <= ld_base;
                        len_reg  <= ld_len;
                    end else if (rd_start) begin
                        base_reg <= rd_base;
                        len_reg  <= rd_len;
                        // A repeat count of zero replays the window once.
                        rep_reg  <= (rd_rep == '0) ? REPW'(1) : rd_rep;
                    end
                end
                S_LOAD: begin
                    if (wr_fire)
                        idx_reg <= idx_reg + AW'(1);
                end
                S_READ: begin
                    if (issue) begin
                        if (idx_at_end) begin
                            idx_reg  <= '0;
                            pass_reg <= pass_reg + REPW'(1);
                        end else begin
                            idx_reg  <= idx_reg + AW'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // SRAM retention enable: cleared by reset, raised on the first edge after release.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) buf_RETN <= 1'b0;
        else       buf_RETN <= 1'b1;
    end

endmodule

// File: tb/tb_weight_buffer_ctrl.sv
// Directed bench for weight_buffer_ctrl with a behavioural SRAM attached.
module tb_weight_buffer_ctrl;
    localparam int DW   = 512;
    localparam int AW   = 6;
    localparam int REPW = 8;

    logic            CLK;
    logic            RSTN;
    logic            ld_start;
    logic [AW-1:0]   ld_base;
    logic [AW:0]     ld_len;
    logic            ld_valid;
    logic [DW-1:0]   ld_data;
    logic            ld_ready;
    logic            rd_start;
    logic [AW-1:0]   rd_base;
    logic [AW:0]     rd_len;
    logic [REPW-1:0] rd_rep;
    logic            rd_stall;
    logic [DW-1:0]   rd_data;
    logic            rd_valid;
    logic            rd_last;
    logic            busy;
    logic            done;
    logic            buf_CEN;
    logic            buf_WEN;
    logic [AW-1:0]   buf_A;
    logic [DW-1:0]   buf_D;
    logic            buf_RETN;
    logic [DW-1:0]   buf_Q;

    int n_checks = 0;
    int n_pass   = 0;

    logic [DW-1:0] mem    [64];
    logic [DW-1:0] shadow [64];   // what the bench itself wrote, per address

    weight_buffer_ctrl #(.DW(DW), .AW(AW), .REPW(REPW)) dut (
        .CLK(CLK), .RSTN(RSTN),
        .ld_start(ld_start), .ld_base(ld_base), .ld_len(ld_len),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
        .rd_start(rd_start), .rd_base(rd_base), .rd_len(rd_len),
        .rd_rep(rd_rep), .rd_stall(rd_stall),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last),
        .busy(busy), .done(done),
        .buf_CEN(buf_CEN), .buf_WEN(buf_WEN), .buf_A(buf_A), .buf_D(buf_D),
        .buf_RETN(buf_RETN), .buf_Q(buf_Q)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // SRAM model: write on CEN&WEN low, registered read, zero on idle cycles.
    always @(posedge CLK) begin
        if (!buf_CEN && !buf_WEN) mem[buf_A] <= buf_D;
        if (!buf_CEN && buf_WEN)  buf_Q <= mem[buf_A];
        else                      buf_Q <= '0;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        #3;
        n_checks++; if (busy !== 1'b0)     $display("FAIL reset_busy: got %0b want 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0)     $display("FAIL reset_done: got %0b want 0", done); else n_pass++;
        n_checks++; if (ld_ready !== 1'b0) $display("FAIL reset_ld_ready: got %0b want 0", ld_ready); else n_pass++;
        n_checks++; if (rd_valid !== 1'b0 || rd_last !== 1'b0) $display("FAIL reset_rd: got valid=%0b last=%0b want 0/0", rd_valid, rd_last); else n_pass++;
        n_checks++; if (buf_CEN !== 1'b1 || buf_WEN !== 1'b1) $display("FAIL reset_cen_wen: got %0b/%0b want 1/1", buf_CEN, buf_WEN); else n_pass++;
        n_checks++; if (buf_A !== 6'd0)    $display("FAIL reset_addr: got %0d want 0", buf_A); else n_pass++;
        n_checks++; if (buf_RETN !== 1'b0) $display("FAIL reset_retn: got %0b want 0", buf_RETN); else n_pass++;
        tick();
        n_checks++; if (buf_RETN !== 1'b0) $display("FAIL reset_retn_held: got %0b want 0", buf_RETN); else n_pass++;
        RSTN = 1'b1;
        tick();
        #3;
        n_checks++; if (buf_RETN !== 1'b1) $display("FAIL retn_after_release: got %0b want 1", buf_RETN); else n_pass++;
        n_checks++; if (busy !== 1'b0)     $display("FAIL idle_after_release: got busy=%0b want 0", busy); else n_pass++;
        $display("reset: released, RETN raised");
        tick();
    endtask

    // One load transaction; valid_mask bit (cycle mod 16) gates ld_valid.
    // Returns the number of LOAD-state cycles taken.
    task automatic run_load(input logic [AW-1:0] base, input logic [AW:0] len,
                            input logic [15:0] valid_mask, input int seed,
                            output int cycles);
        int beats;
        int cyc;
        logic v;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        ld_start = 1'b1; ld_base = base; ld_len = len;
        #3;
        n_checks++; if (busy !== 1'b0 || ld_ready !== 1'b0) $display("FAIL ld_idle: got busy=%0b ready=%0b want 0/0", busy, ld_ready); else n_pass++;
        tick();
        ld_start = 1'b0;
        beats = 0;
        cyc   = 0;
        while (beats < int'(len) && cyc < 100) begin
            v = valid_mask[cyc % 16];
            a = base + AW'(beats);
            d = DW'(seed + beats);
            ld_valid = v;
            ld_data  = d;
            #3;
            n_checks++; if (ld_ready !== 1'b1) $display("FAIL ld_ready: got %0b want 1", ld_ready); else n_pass++;
            n_checks++; if (buf_WEN !== ~v)    $display("FAIL ld_wen c%0d: got %0b want %0b", cyc, buf_WEN, ~v); else n_pass++;
            n_checks++; if (done !== 1'b0)     $display("FAIL ld_early_done: got %0b want 0", done); else n_pass++;
            if (v) begin
                n_checks++; if (buf_A !== a || buf_D !== d) $display("FAIL ld_addr_data: got A=%0d D=%0h want A=%0d D=%0h", buf_A, buf_D, a, d); else n_pass++;
                shadow[a] = d;
                beats++;
            end
            tick();
            cyc++;
        end
        n_checks++; if (beats != int'(len)) $display("FAIL ld_timeout: got %0d beats want %0d", beats, len); else n_pass++;
        ld_valid = 1'b0;
        ld_data  = '0;
        #3;
        n_checks++; if (done !== 1'b1 || busy !== 1'b1) $display("FAIL ld_done: got done=%0b busy=%0b want 1/1", done, busy); else n_pass++;
        n_checks++; if (ld_ready !== 1'b0 || buf_WEN !== 1'b1) $display("FAIL ld_done_pins: got ready=%0b wen=%0b want 0/1", ld_ready, buf_WEN); else n_pass++;
        tick();
        #3;
        n_checks++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL ld_back_idle: got done=%0b busy=%0b want 0/0", done, busy); else n_pass++;
        cycles = cyc;
        $display("load base=%0d len=%0d beats=%0d cycles=%0d", base, len, beats, cyc);
        tick();
    endtask

    // One read transaction; stall_mask bit (cycle mod 16) drives rd_stall.
    task automatic run_read(input logic [AW-1:0] base, input logic [AW:0] len,
                            input logic [REPW-1:0] rep, input logic [15:0] stall_mask,
                            output int beats, output int cycles);
        int total;
        int issued;
        int cyc;
        logic s;
        logic prev_issue;
        logic [AW-1:0] prev_addr;
        logic [AW-1:0] a;
        total = int'(len) * ((rep == 0) ? 1 : int'(rep));
        rd_start = 1'b1; rd_base = base; rd_len = len; rd_rep = rep;
        #3;
        n_checks++; if (busy !== 1'b0) $display("FAIL rd_idle: got busy=%0b want 0", busy); else n_pass++;
        tick();
        rd_start   = 1'b0;
        issued     = 0;
        cyc        = 0;
        beats      = 0;
        prev_issue = 1'b0;
        prev_addr  = '0;
        while (issued < total && cyc < 200) begin
            s = stall_mask[cyc % 16];
            a = base + AW'(issued % int'(len));
            rd_stall = s;
            #3;
            n_checks++; if (buf_CEN !== s || buf_WEN !== 1'b1) $display("FAIL rd_cen c%0d: got cen=%0b wen=%0b want %0b/1", cyc, buf_CEN, buf_WEN, s); else n_pass++;
            if (!s) begin
                n_checks++; if (buf_A !== a) $display("FAIL rd_addr c%0d: got %0d want %0d", cyc, buf_A, a); else n_pass++;
            end
            n_checks++; if (rd_valid !== prev_issue) $display("FAIL rd_valid c%0d: got %0b want %0b", cyc, rd_valid, prev_issue); else n_pass++;
            n_checks++; if (rd_last !== 1'b0 || done !== 1'b0) $display("FAIL rd_early_last c%0d: got last=%0b done=%0b want 0/0", cyc, rd_last, done); else n_pass++;
            if (prev_issue) begin
                n_checks++; if (rd_data !== shadow[prev_addr]) $display("FAIL rd_data c%0d: got %0h want %0h", cyc, rd_data, shadow[prev_addr]); else n_pass++;
            end
            if (rd_valid === 1'b1) beats++;
            prev_issue = ~s;
            if (!s) begin
                prev_addr = a;
                issued++;
            end
            tick();
            cyc++;
        end
        n_checks++; if (issued != total) $display("FAIL rd_timeout: got %0d issues want %0d", issued, total); else n_pass++;
        rd_stall = 1'b0;
        #3;
        n_checks++; if (rd_valid !== 1'b1 || rd_last !== 1'b1) $display("FAIL rd_final: got valid=%0b last=%0b want 1/1", rd_valid, rd_last); else n_pass++;
        n_checks++; if (done !== 1'b1 || buf_CEN !== 1'b1) $display("FAIL rd_done: got done=%0b cen=%0b want 1/1", done, buf_CEN); else n_pass++;
        n_checks++; if (rd_data !== shadow[prev_addr]) $display("FAIL rd_final_data: got %0h want %0h", rd_data, shadow[prev_addr]); else n_pass++;
        if (rd_valid === 1'b1) beats++;
        tick();
        #3;
        n_checks++; if (rd_valid !== 1'b0 || rd_last !== 1'b0 || done !== 1'b0 || busy !== 1'b0) $display("FAIL rd_back_idle: got v=%0b l=%0b d=%0b b=%0b want 0/0/0/0", rd_valid, rd_last, done, busy); else n_pass++;
        cycles = cyc;
        $display("read base=%0d len=%0d rep=%0d beats=%0d cycles=%0d", base, len, rep, beats, cyc);
        tick();
    endtask

    task automatic test_load();
        int cyc;
        run_load(6'd0, 7'd4, 16'hFFFF, 1, cyc);
        n_checks++; if (cyc != 4) $display("FAIL load_cycles: got %0d want 4", cyc); else n_pass++;
    endtask

    task automatic test_load_gaps();
        int cyc;
        run_load(6'd10, 7'd2, 16'h5555, 'h50, cyc);
        n_checks++; if (cyc != 3) $display("FAIL gap_cycles: got %0d want 3", cyc); else n_pass++;
    endtask

    task automatic test_load_wrap();
        int cyc;
        run_load(6'd62, 7'd4, 16'hFFFF, 'hA0, cyc);
        n_checks++; if (mem[0] !== 512'hA2 || mem[1] !== 512'hA3) $display("FAIL wrap_mem: got %0h,%0h want a2,a3", mem[0], mem[1]); else n_pass++;
    endtask

    task automatic test_read_repeat();
        int beats;
        int cyc;
        run_read(6'd62, 7'd3, 8'd2, 16'h0000, beats, cyc);
        n_checks++; if (beats != 6 || cyc != 6) $display("FAIL repeat_beats: got %0d beats %0d cycles want 6/6", beats, cyc); else n_pass++;
    endtask

    task automatic test_read_stall();
        int beats;
        int cyc;
        run_read(6'd0, 7'd4, 8'd1, 16'h0006, beats, cyc);
        n_checks++; if (beats != 4 || cyc != 6) $display("FAIL stall_beats: got %0d beats %0d cycles want 4/6", beats, cyc); else n_pass++;
    endtask

    task automatic test_rep_zero();
        int beats;
        int cyc;
        run_read(6'd10, 7'd2, 8'd0, 16'h0000, beats, cyc);
        n_checks++; if (beats != 2) $display("FAIL rep_zero_beats: got %0d want 2", beats); else n_pass++;
    endtask

    task automatic test_len_zero();
        rd_start = 1'b1; rd_base = 6'd5; rd_len = 7'd0; rd_rep = 8'd3;
        #3;
        n_checks++; if (buf_CEN !== 1'b1) $display("FAIL len0_cen_start: got %0b want 1", buf_CEN); else n_pass++;
        tick();
        rd_start = 1'b0;
        #3;
        n_checks++; if (done !== 1'b1 || buf_CEN !== 1'b1) $display("FAIL len0_done: got done=%0b cen=%0b want 1/1", done, buf_CEN); else n_pass++;
        tick();
        #3;
        n_checks++; if (busy !== 1'b0 || rd_valid !== 1'b0) $display("FAIL len0_idle: got busy=%0b valid=%0b want 0/0", busy, rd_valid); else n_pass++;
        $display("read base=5 len=0 rep=3 done immediately");
        tick();
    endtask

    task automatic test_simul_start();
        ld_start = 1'b1; ld_base = 6'd20; ld_len = 7'd1;
        rd_start = 1'b1; rd_base = 6'd0;  rd_len = 7'd4; rd_rep = 8'd1;
        tick();
        ld_start = 1'b0; rd_start = 1'b0;
        ld_valid = 1'b1; ld_data = 512'h55;
        #3;
        n_checks++; if (ld_ready !== 1'b1 || buf_WEN !== 1'b0 || buf_A !== 6'd20) $display("FAIL simul_load: got ready=%0b wen=%0b A=%0d want 1/0/20", ld_ready, buf_WEN, buf_A); else n_pass++;
        shadow[20] = 512'h55;
        tick();
        ld_valid = 1'b0; ld_data = '0;
        #3;
        n_checks++; if (done !== 1'b1) $display("FAIL simul_done: got %0b want 1", done); else n_pass++;
        tick();
        #3;
        n_checks++; if (busy !== 1'b0 || rd_valid !== 1'b0) $display("FAIL simul_no_read: got busy=%0b valid=%0b want 0/0", busy, rd_valid); else n_pass++;
        $display("simultaneous start: load only, addr 20");
        tick();
    endtask

    task automatic test_ld_during_read();
        rd_start = 1'b1; rd_base = 6'd0; rd_len = 7'd2; rd_rep = 8'd1;
        tick();
        rd_start = 1'b0;
        ld_start = 1'b1; ld_base = 6'd30; ld_len = 7'd2; ld_valid = 1'b1; ld_data = 512'hEE;
        #3;
        n_checks++; if (ld_ready !== 1'b0 || buf_WEN !== 1'b1 || buf_A !== 6'd0) $display("FAIL ldr_ignore0: got ready=%0b wen=%0b A=%0d want 0/1/0", ld_ready, buf_WEN, buf_A); else n_pass++;
        tick();
        #3;
        n_checks++; if (buf_WEN !== 1'b1 || buf_A !== 6'd1 || rd_valid !== 1'b1) $display("FAIL ldr_ignore1: got wen=%0b A=%0d valid=%0b want 1/1/1", buf_WEN, buf_A, rd_valid); else n_pass++;
        n_checks++; if (rd_data !== shadow[0]) $display("FAIL ldr_data0: got %0h want %0h", rd_data, shadow[0]); else n_pass++;
        tick();
        #3;
        n_checks++; if (done !== 1'b1 || rd_last !== 1'b1 || rd_data !== shadow[1]) $display("FAIL ldr_done: got done=%0b last=%0b data=%0h want 1/1/%0h", done, rd_last, rd_data, shadow[1]); else n_pass++;
        tick();
        ld_start = 1'b0; ld_valid = 1'b0; ld_data = '0;
        #3;
        n_checks++; if (busy !== 1'b0 || ld_ready !== 1'b0) $display("FAIL ldr_idle: got busy=%0b ready=%0b want 0/0", busy, ld_ready); else n_pass++;
        $display("ld_start during read ignored");
        tick();
    endtask

    task automatic test_async_reset();
        int cyc;
        rd_start = 1'b1; rd_base = 6'd0; rd_len = 7'd4; rd_rep = 8'd3;
        tick();
        rd_start = 1'b0; rd_stall = 1'b0;
        tick();
        tick();
        #2;
        RSTN = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0 || ld_ready !== 1'b0) $display("FAIL arst_ctrl: got busy=%0b done=%0b ready=%0b want 0/0/0", busy, done, ld_ready); else n_pass++;
        n_checks++; if (rd_valid !== 1'b0 || rd_last !== 1'b0) $display("FAIL arst_rd: got valid=%0b last=%0b want 0/0", rd_valid, rd_last); else n_pass++;
        n_checks++; if (buf_CEN !== 1'b1 || buf_WEN !== 1'b1 || buf_A !== 6'd0) $display("FAIL arst_pins: got cen=%0b wen=%0b A=%0d want 1/1/0", buf_CEN, buf_WEN, buf_A); else n_pass++;
        n_checks++; if (buf_RETN !== 1'b0) $display("FAIL arst_retn: got %0b want 0", buf_RETN); else n_pass++;
        tick();
        #3;
        n_checks++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL arst_hold: got done=%0b busy=%0b want 0/0", done, busy); else n_pass++;
        RSTN = 1'b1;
        #1;
        n_checks++; if (buf_RETN !== 1'b0) $display("FAIL arst_retn_pre_edge: got %0b want 0", buf_RETN); else n_pass++;
        tick();
        #3;
        n_checks++; if (buf_RETN !== 1'b1 || busy !== 1'b0 || done !== 1'b0) $display("FAIL arst_release: got retn=%0b busy=%0b done=%0b want 1/0/0", buf_RETN, busy, done); else n_pass++;
        $display("async reset mid-read: aborted without done");
        tick();
        run_load(6'd40, 7'd2, 16'hFFFF, 'h77, cyc);
        n_checks++; if (cyc != 2) $display("FAIL post_reset_load: got %0d cycles want 2", cyc); else n_pass++;
    endtask

    initial begin
        RSTN = 1'b0;
        ld_start = 1'b0; ld_base = '0; ld_len = '0; ld_valid = 1'b0; ld_data = '0;
        rd_start = 1'b0; rd_base = '0; rd_len = '0; rd_rep = '0; rd_stall = 1'b0;
        for (int i = 0; i < 64; i++) shadow[i] = '0;
        test_reset();
        test_load();
        test_load_gaps();
        test_load_wrap();
        test_read_repeat();
        test_read_stall();
        test_rep_zero();
        test_len_zero();
        test_simul_start();
        test_ld_during_read();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
